// File: rtl/usb_bit_stuffer.sv
// rtl/usb_bit_stuffer.sv - USB bit stuffer with optional NRZI line encoding
module usb_bit_stuffer #(
    parameter int RUN_LEN = 6,
    parameter bit NRZI_EN = 1'b1
) (
    input  logic       Usb_Stuff_Clk,
    input  logic       Usb_Stuff_Rst_N,
    input  logic       Usb_Stuff_Data_In,
    input  logic       Usb_Stuff_Valid_In,
    input  logic       Usb_Stuff_Eop_In,
    output logic       Usb_Stuff_Ready_Out,
    output logic       Usb_Stuff_Data_Out,
    output logic       Usb_Stuff_Valid_Out,
    output logic       Usb_Stuff_Flag,
    output logic [3:0] Usb_Stuff_Run_Cnt
);

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_SEND  = 2'd1,
        ST_STUFF = 2'd2
    } stuff_state_e;

    localparam logic [3:0] RUN_MAX = 4'(RUN_LEN);

    stuff_state_e state, state_nxt;
    logic [3:0]   run_cnt, run_cnt_nxt;
    logic [3:0]   run_inc;
    logic         stuff_eop, stuff_eop_nxt;
    logic         nrz_q, nrz_nxt;
    logic         valid_q, valid_nxt;
    logic         flag_q, flag_nxt;
    logic         last_q, last_nxt;
    logic         level_q, level_nxt;
    logic         level_base;
    logic         emit;
    logic         emit_bit;
    logic         xfer;

    assign Usb_Stuff_Ready_Out = Usb_Stuff_Rst_N && (state != ST_STUFF);
    assign xfer                = Usb_Stuff_Valid_In && Usb_Stuff_Ready_Out;
    assign run_inc             = run_cnt + 4'd1;

    always_ff @(posedge Usb_Stuff_Clk) begin
        if (!Usb_Stuff_Rst_N) begin
            state     <= ST_IDLE;
            run_cnt   <= 4'd0;
            stuff_eop <= 1'b0;
            nrz_q     <= 1'b0;
            valid_q   <= 1'b0;
            flag_q    <= 1'b0;
            last_q    <= 1'b0;
            level_q   <= 1'b1;
        end else begin
            state     <= state_nxt;
            run_cnt   <= run_cnt_nxt;
            stuff_eop <= stuff_eop_nxt;
            nrz_q     <= nrz_nxt;
            valid_q   <= valid_nxt;
            flag_q    <= flag_nxt;
            last_q    <= last_nxt;
            level_q   <= level_nxt;
        end
    end

    always_comb begin
        state_nxt     = state;
        run_cnt_nxt   = run_cnt;
        stuff_eop_nxt = stuff_eop;
        emit          = 1'b0;
        emit_bit      = 1'b0;
        flag_nxt      = 1'b0;
        last_nxt      = 1'b0;
        case (state)
            ST_STUFF: begin
                emit          = 1'b1;
                flag_nxt      = 1'b1;
                last_nxt      = stuff_eop;
                run_cnt_nxt   = 4'd0;
                stuff_eop_nxt = 1'b0;
                state_nxt     = stuff_eop ? ST_IDLE : ST_SEND;
            end
            default: begin
                if (xfer) begin
                    emit     = 1'b1;
                    emit_bit = Usb_Stuff_Data_In;
                    if (Usb_Stuff_Data_In && (run_inc == RUN_MAX)) begin
                        // Stuffing wins over EOP; the EOP is remembered for the stuff cycle
                        run_cnt_nxt   = RUN_MAX;
                        stuff_eop_nxt = Usb_Stuff_Eop_In;
                        state_nxt     = ST_STUFF;
                    end else if (Usb_Stuff_Eop_In) begin
                        run_cnt_nxt = 4'd0;
                        last_nxt    = 1'b1;
                        state_nxt   = ST_IDLE;
                    end else begin
                        run_cnt_nxt = Usb_Stuff_Data_In ? run_inc : 4'd0;
                        state_nxt   = ST_SEND;
                    end
                end
            end
        endcase
    end

    // A packet's closing bit sends the line back to J before anything new is encoded
    assign level_base = last_q ? 1'b1 : level_q;

    always_comb begin
        level_nxt = level_base;
        if (emit && !emit_bit) begin
            level_nxt = ~level_base;
        end
        valid_nxt = emit;
        nrz_nxt   = emit & emit_bit;
    end

    assign Usb_Stuff_Data_Out  = NRZI_EN ? level_q : (valid_q & nrz_q);
    assign Usb_Stuff_Valid_Out = valid_q;
    assign Usb_Stuff_Flag      = flag_q;
    assign Usb_Stuff_Run_Cnt   = run_cnt;

endmodule

// File: tb/tb_usb_bit_stuffer.sv
// tb/tb_usb_bit_stuffer.sv - directed self-checking bench for usb_bit_stuffer
module tb_usb_bit_stuffer;

    logic            clk = 1'b0;
    logic            rst_n = 1'b0;
    logic            din = 1'b0;
    logic            vin = 1'b0;
    logic            eop = 1'b0;
    logic [2:0]      rdy, dout, vout, flg;
    logic [2:0][3:0] cnt;

    int          n_chk = 0;
    int          n_pass = 0;
    int          sel = 0;
    logic        mon_en = 1'b0;
    logic [31:0] got_data, got_flag;
    int          got_len, rlow;

    always #5 clk = ~clk;

    // instance 0: RUN_LEN 6 NRZ, 1: RUN_LEN 6 NRZI, 2: RUN_LEN 4 NRZI
    usb_bit_stuffer #(.RUN_LEN(6), .NRZI_EN(1'b0)) dut_nrz (
        .Usb_Stuff_Clk(clk), .Usb_Stuff_Rst_N(rst_n), .Usb_Stuff_Data_In(din),
        .Usb_Stuff_Valid_In(vin), .Usb_Stuff_Eop_In(eop), .Usb_Stuff_Ready_Out(rdy[0]),
        .Usb_Stuff_Data_Out(dout[0]), .Usb_Stuff_Valid_Out(vout[0]), .Usb_Stuff_Flag(flg[0]),
        .Usb_Stuff_Run_Cnt(cnt[0]));

    usb_bit_stuffer #(.RUN_LEN(6), .NRZI_EN(1'b1)) dut_nrzi (
        .Usb_Stuff_Clk(clk), .Usb_Stuff_Rst_N(rst_n), .Usb_Stuff_Data_In(din),
        .Usb_Stuff_Valid_In(vin), .Usb_Stuff_Eop_In(eop), .Usb_Stuff_Ready_Out(rdy[1]),
        .Usb_Stuff_Data_Out(dout[1]), .Usb_Stuff_Valid_Out(vout[1]), .Usb_Stuff_Flag(flg[1]),
        .Usb_Stuff_Run_Cnt(cnt[1]));

    usb_bit_stuffer #(.RUN_LEN(4), .NRZI_EN(1'b1)) dut_r4 (
        .Usb_Stuff_Clk(clk), .Usb_Stuff_Rst_N(rst_n), .Usb_Stuff_Data_In(din),
        .Usb_Stuff_Valid_In(vin), .Usb_Stuff_Eop_In(eop), .Usb_Stuff_Ready_Out(rdy[2]),
        .Usb_Stuff_Data_Out(dout[2]), .Usb_Stuff_Valid_Out(vout[2]), .Usb_Stuff_Flag(flg[2]),
        .Usb_Stuff_Run_Cnt(cnt[2]));

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    endtask

    // Advance to the next falling edge and record the selected instance's output
    task automatic tick();
        @(negedge clk);
        if (mon_en) begin
            if (vout[sel]) begin
                got_data = {got_data[30:0], dout[sel]};
                got_flag = {got_flag[30:0], flg[sel]};
                got_len++;
            end
            if (!rdy[sel]) rlow++;
        end
    endtask

    task automatic idle(input int n);
        vin = 1'b0;
        repeat (n) tick();
    endtask

    task automatic send(input logic d, input logic e);
        int n;
        din = d;
        eop = e;
        vin = 1'b1;
        n = 0;
        while (!rdy[sel] && n < 20) begin
            tick();
            n++;
        end
        if (n >= 20) check("send_timeout", {31'd0, rdy[sel]}, 32'd1);
        tick();
        vin = 1'b0;
    endtask

    task automatic start_mon();
        got_data = 32'd0;
        got_flag = 32'd0;
        got_len  = 0;
        rlow     = 0;
        mon_en   = 1'b1;
    endtask

    task automatic do_reset(input int s);
        sel    = s;
        mon_en = 1'b0;
        rst_n  = 1'b0;
        vin    = 1'b0;
        din    = 1'b0;
        eop    = 1'b0;
        tick();
        check("rst_ready", {31'd0, rdy[sel]}, 32'd0);
        check("rst_valid", {31'd0, vout[sel]}, 32'd0);
        check("rst_flag", {31'd0, flg[sel]}, 32'd0);
        check("rst_cnt", {28'd0, cnt[sel]}, 32'd0);
        check("rst_dout", {31'd0, dout[sel]}, (sel == 0) ? 32'd0 : 32'd1);
        rst_n = 1'b1;
        tick();
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        // Seven 1s then a 0, continuous valid, NRZ
        do_reset(0);
        start_mon();
        repeat (7) send(1'b1, 1'b0);
        send(1'b0, 1'b1);
        idle(3);
        check("A_len", got_len, 32'd9);
        check("A_data", got_data, 32'h1FA);
        check("A_flag", got_flag, 32'h004);
        check("A_ready_low", rlow, 32'd1);

        // NRZI encoding of 0,0,1,1 from idle
        do_reset(1);
        start_mon();
        send(1'b0, 1'b0);
        send(1'b0, 1'b0);
        send(1'b1, 1'b0);
        send(1'b1, 1'b1);
        idle(2);
        check("B_len", got_len, 32'd4);
        check("B_data", got_data, 32'h7);
        check("B_flag", got_flag, 32'h0);
        // Single-bit packet: line drops to K, then returns to J
        send(1'b0, 1'b1);
        check("B2_valid", {31'd0, vout[1]}, 32'd1);
        check("B2_dout", {31'd0, dout[1]}, 32'd0);
        idle(1);
        check("B2_idle_valid", {31'd0, vout[1]}, 32'd0);
        check("B2_idle_level", {31'd0, dout[1]}, 32'd1);

        // Gaps in valid do not break a run
        do_reset(0);
        start_mon();
        repeat (3) send(1'b1, 1'b0);
        idle(1);
        check("C_gap_cnt1", {28'd0, cnt[0]}, 32'd3);
        idle(2);
        check("C_gap_cnt3", {28'd0, cnt[0]}, 32'd3);
        repeat (3) send(1'b1, 1'b0);
        check("C_stuff_ready", {31'd0, rdy[0]}, 32'd0);
        check("C_stuff_cnt", {28'd0, cnt[0]}, 32'd6);
        idle(3);
        check("C_len", got_len, 32'd7);
        check("C_data", got_data, 32'h7E);
        check("C_flag", got_flag, 32'h01);
        check("C_cnt_after", {28'd0, cnt[0]}, 32'd0);

        // RUN_LEN 4 with EOP on the run-completing bit
        do_reset(2);
        start_mon();
        repeat (3) send(1'b1, 1'b0);
        send(1'b1, 1'b1);
        check("D_stuff_ready", {31'd0, rdy[2]}, 32'd0);
        check("D_stuff_cnt", {28'd0, cnt[2]}, 32'd4);
        send(1'b1, 1'b0);
        check("D_new_cnt", {28'd0, cnt[2]}, 32'd1);
        send(1'b1, 1'b1);
        idle(2);
        check("D_len", got_len, 32'd7);
        check("D_data", got_data, 32'h7B);
        check("D_flag", got_flag, 32'h04);
        check("D_idle_level", {31'd0, dout[2]}, 32'd1);
        check("D_cnt_after", {28'd0, cnt[2]}, 32'd0);

        // Reset during the stuff cycle discards the pending stuff bit
        do_reset(1);
        send(1'b0, 1'b0);
        repeat (6) send(1'b1, 1'b0);
        check("E_in_stuff", {31'd0, rdy[1]}, 32'd0);
        check("E_level_low", {31'd0, dout[1]}, 32'd0);
        rst_n = 1'b0;
        tick();
        check("E_rst_valid", {31'd0, vout[1]}, 32'd0);
        check("E_rst_flag", {31'd0, flg[1]}, 32'd0);
        check("E_rst_cnt", {28'd0, cnt[1]}, 32'd0);
        check("E_rst_dout", {31'd0, dout[1]}, 32'd1);
        rst_n = 1'b1;
        send(1'b0, 1'b1);
        check("E_fresh_valid", {31'd0, vout[1]}, 32'd1);
        check("E_fresh_dout", {31'd0, dout[1]}, 32'd0);
        check("E_fresh_flag", {31'd0, flg[1]}, 32'd0);
        idle(2);

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule

// File: doc/usb_bit_stuffer.md
USB_BIT_STUFFER -- requirements
Module: usb_bit_stuffer

Interface
REQ-001 Parameter RUN_LEN, default 6: number of consecutive accepted 1 bits that forces one stuffed 0; legal range 2..15.
REQ-002 Parameter NRZI_EN, default 1: 1 = NRZI-encode the output stream; 0 = output the stuffed NRZ stream directly.
REQ-003 Usb_Stuff_Clk  input  1  single clock; all state changes on its rising edge.
REQ-004 Usb_Stuff_Rst_N  input  1  synchronous, active-low reset, sampled on rising edge of Usb_Stuff_Clk.
REQ-005 Usb_Stuff_Data_In  input  1  NRZ payload bit.
REQ-006 Usb_Stuff_Valid_In  input  1  Data_In/Eop_In qualified this cycle.
REQ-007 Usb_Stuff_Eop_In  input  1  marks the accepted bit as the last bit of the packet.
REQ-008 Usb_Stuff_Ready_Out  output  1  block accepts a bit this cycle; transfer = Valid_In & Ready_Out.
REQ-009 Usb_Stuff_Data_Out  output  1  line bit (NRZI or NRZ per NRZI_EN).
REQ-010 Usb_Stuff_Valid_Out  output  1  Data_Out is a real line bit this cycle.
REQ-011 Usb_Stuff_Flag  output  1  Data_Out this cycle is an inserted stuff bit.
REQ-012 Usb_Stuff_Run_Cnt  output  4  current count of consecutive 1s.

Function
REQ-013 States: IDLE, SEND, STUFF; IDLE and SEND identical except SEND means a packet is open.
REQ-014 IDLE/SEND: Ready_Out=1; on transfer the NRZ bit is registered and presented on the next cycle with Valid_Out=1, Flag=0 (latency exactly 1 cycle).
REQ-015 Accepted 1 increments Run_Cnt; accepted 0 clears Run_Cnt; no transfer leaves Run_Cnt unchanged (gaps do not break a run).
REQ-016 When an accepted 1 makes Run_Cnt reach RUN_LEN, next state is STUFF; Run_Cnt shows RUN_LEN for that cycle.
REQ-017 STUFF: Ready_Out=0 (combinationally, this cycle); next cycle output is NRZ 0 with Valid_Out=1, Flag=1; Run_Cnt clears to 0; state returns to SEND, or IDLE if the bit that triggered STUFF carried Eop_In.
REQ-018 Stuff insertion is never suppressed, including when the run-completing bit carries Eop_In.
REQ-019 Accepted bit with Eop_In and no pending stuff: Run_Cnt clears after that bit, state goes to IDLE.
REQ-020 NRZI_EN=1: line level register starts at 1 (J); NRZ 0 (payload or stuff) toggles the level, NRZ 1 holds; Data_Out = new level.
REQ-021 NRZI_EN=1: line level returns to 1 on the cycle after the last output bit of a packet (EOP bit or its stuff bit) is emitted.
REQ-022 Valid_Out=0 cycles: Data_Out holds the line level (NRZI) or 0 (NRZ); Flag=0.
REQ-023 Run_Cnt width is 4 bits; it never exceeds RUN_LEN.
REQ-024 Valid_In in STUFF is not accepted; the upstream holds the same bit until Ready_Out=1.

Reset
REQ-025 Reset low: state IDLE, Run_Cnt=0, Valid_Out=0, Flag=0, Data_Out=1 if NRZI_EN=1 else 0, line level=1, Ready_Out=0 during the reset cycle.
REQ-026 Reset mid-packet or in STUFF discards any pending stuff bit and the held output bit; first transfer after release starts a fresh packet.

Verification
REQ-027 RUN_LEN=6, NRZI_EN=0, stream 1111111 0 continuous valid -> Data_Out 1,1,1,1,1,1,0(Flag=1),1,0; Ready_Out low exactly one cycle after sixth 1.
REQ-028 RUN_LEN=6, NRZI_EN=1, stream 0,0,1,1 from idle -> Data_Out 0,1,1,1.
REQ-029 RUN_LEN=6, NRZI_EN=0, 111 then 3 idle cycles then 111 -> stuff bit after sixth 1; Run_Cnt held at 3 during gap.
REQ-030 RUN_LEN=4, six 1s with Eop_In on fourth -> stuff 0 after fourth, state IDLE, next packet's first bit not affected by prior run; NRZI level back to 1.
REQ-031 Reset asserted in STUFF cycle -> no Flag pulse, Valid_Out=0, Run_Cnt=0, Data_Out=1 (NRZI_EN=1) next cycle.
REQ-032 Random stream, random Valid_In gaps, both NRZI_EN values -> decoded/destuffed output equals input; no run longer than RUN_LEN on NRZ side.
